// File: rtl/sm_seq_detect_pkg.sv
// Shared LED field layout, widths and sizing helper for the sequence-detector slice.
package sm_seq_detect_pkg;

    localparam int unsigned CNT_LSB   = 0;
    localparam int unsigned PROG_LSB  = 8;
    localparam int unsigned MATCH_BIT = 15;
    localparam int unsigned CNT_W     = 8;
    localparam int unsigned PROG_W    = 4;

    // Bits needed to hold values 0..v-1; never less than one.
    function automatic int unsigned clog2(input longint unsigned v);
        int unsigned     r;
        longint unsigned p;
        r = 0;
        p = 1;
        while (p < v) begin
            p = p << 1;
            r++;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/sm_seq_detect_debounce.sv
// BTNC synchroniser and debouncer: level follows the button once stable, step pulses on press.
module sm_debounce
    import sm_seq_detect_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic step
);

    localparam int unsigned CW = clog2(longint'(DEB_CYCLES));
    localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

    logic          btn_m;
    logic          btn_s;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_m <= 1'b0;
            btn_s <= 1'b0;
            level <= 1'b0;
            step  <= 1'b0;
            cnt   <= '0;
        end else begin
            btn_m <= btn;
            btn_s <= btn_m;
            step  <= 1'b0;
            // Any cycle agreeing with the current level restarts the stability count.
            if (btn_s != level) begin
                if (cnt == LAST) begin
                    level <= btn_s;
                    step  <= btn_s;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/sm_seq_detect.sv
// Serial pattern detector: debounced BTNC clocks SW[0] into a prefix-matching automaton.
module sm_seq_detect
    import sm_seq_detect_pkg::*;
#(
    parameter int unsigned          PAT_W          = 4,
    parameter logic [PAT_W-1:0]     PATTERN        = 4'b1011,
    parameter int unsigned          DEB_CYCLES     = 1000000,
    parameter int unsigned          STRETCH_CYCLES = 50000000
) (
    input  logic        CLK100MHZ,
    input  logic        CPU_RESETN,
    input  logic [2:0]  SW,
    input  logic        BTNC,
    output logic [15:0] LED
);

    localparam int unsigned TBL_W = 2 * (PAT_W + 1) * PROG_W;
    localparam int unsigned STR_W = clog2(longint'(STRETCH_CYCLES) + 1);

    typedef logic [PROG_W-1:0] prog_t;

    // Entry (2*k + b) is the longest pattern prefix that ends the string
    // "first k pattern bits, then b"; pattern bit 0 is PATTERN[PAT_W-1].
    function automatic logic [TBL_W-1:0] build_trans();
        logic [TBL_W-1:0] t;
        logic [PAT_W:0]   s;
        int unsigned      lim;
        int unsigned      best;
        logic             ok;
        t = '0;
        for (int unsigned k = 0; k <= PAT_W; k++) begin
            for (int unsigned b = 0; b < 2; b++) begin
                s = '0;
                for (int unsigned j = 0; j < k; j++) begin
                    s[j] = PATTERN[PAT_W-1-j];
                end
                s[k] = b[0];
                lim  = (k + 1 < PAT_W) ? k + 1 : PAT_W;
                best = 0;
                for (int unsigned len = 1; len <= lim; len++) begin
                    ok = 1'b1;
                    for (int unsigned i = 0; i < len; i++) begin
                        if (PATTERN[PAT_W-1-i] != s[k+1-len+i]) begin
                            ok = 1'b0;
                        end
                    end
                    if (ok) begin
                        best = len;
                    end
                end
                t[(2*k+b)*PROG_W +: PROG_W] = prog_t'(best);
            end
        end
        return t;
    endfunction

    localparam logic [TBL_W-1:0] TRANS = build_trans();
    localparam prog_t            FULL  = prog_t'(PAT_W);

    logic [2:0]       sw_m;
    logic [2:0]       sw_s;
    logic             btn_level;
    logic             step;
    prog_t            state;
    prog_t            cur;
    prog_t            nxt;
    logic [PROG_W:0]  sel;
    logic [CNT_W-1:0] count;
    logic [STR_W-1:0] stretch;

    wire din     = sw_s[0];
    wire overlap = sw_s[1];
    wire clr     = sw_s[2];

    sm_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_deb (
        .clk   (CLK100MHZ),
        .rst_n (CPU_RESETN),
        .btn   (BTNC),
        .level (btn_level),
        .step  (step)
    );

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            sw_m <= '0;
            sw_s <= '0;
        end else begin
            sw_m <= SW;
            sw_s <= sw_m;
        end
    end

    // Non-overlapping mode restarts from the empty match once the pattern completed.
    always_comb begin
        cur = (state == FULL && !overlap) ? '0 : state;
        sel = {cur, din};
        nxt = TRANS[sel*PROG_W +: PROG_W];
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state   <= '0;
            count   <= '0;
            stretch <= '0;
        end else if (clr) begin
            state   <= '0;
            count   <= '0;
            stretch <= '0;
        end else begin
            if (stretch != '0) begin
                stretch <= stretch - 1'b1;
            end
            if (step && btn_level) begin
                state <= nxt;
                if (nxt == FULL) begin
                    count   <= count + 1'b1;
                    stretch <= STR_W'(STRETCH_CYCLES);
                end
            end
        end
    end

    always_comb begin
        LED                         = '0;
        LED[CNT_LSB +: CNT_W]       = count;
        LED[PROG_LSB +: PROG_W]     = state;
        LED[MATCH_BIT]              = (stretch != '0);
    end

endmodule

// File: tb/tb_sm_seq_detect.sv
// Directed bench for sm_seq_detect: a slow-button instance and a fast-button overlap instance.
module tb_sm_seq_detect;

    logic        clk;
    logic        rst_n;
    logic [2:0]  sw_m;
    logic        btn_m;
    logic [15:0] led_m;
    logic [2:0]  sw_f;
    logic        btn_f;
    logic [15:0] led_f;

    int checks;
    int errors;
    int run_m, last_run_m;
    int run_f, last_run_f;

    sm_seq_detect #(
        .PAT_W          (4),
        .PATTERN        (4'b1011),
        .DEB_CYCLES     (4),
        .STRETCH_CYCLES (8)
    ) dut (
        .CLK100MHZ  (clk),
        .CPU_RESETN (rst_n),
        .SW         (sw_m),
        .BTNC       (btn_m),
        .LED        (led_m)
    );

    sm_seq_detect #(
        .PAT_W          (4),
        .PATTERN        (4'b1010),
        .DEB_CYCLES     (1),
        .STRETCH_CYCLES (16)
    ) dut_f (
        .CLK100MHZ  (clk),
        .CPU_RESETN (rst_n),
        .SW         (sw_f),
        .BTNC       (btn_f),
        .LED        (led_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Length of the most recent completed LED[15] lit period, in cycles.
    always @(negedge clk) begin
        if (led_m[15]) run_m++;
        else if (run_m > 0) begin last_run_m = run_m; run_m = 0; end
        if (led_f[15]) run_f++;
        else if (run_f > 0) begin last_run_f = run_f; run_f = 0; end
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic main_step(input logic b);
        sw_m[0] = b;
        btn_m   = 1'b1;
        repeat (8) @(posedge clk);
        #1 btn_m = 1'b0;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic main_seq4();
        main_step(1'b1);
        main_step(1'b0);
        main_step(1'b1);
        main_step(1'b1);
    endtask

    task automatic main_clear();
        sw_m[2] = 1'b1;
        repeat (4) @(posedge clk);
        #1 sw_m[2] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Five-cycle step period on the DEB_CYCLES=1 instance.
    task automatic fast_step(input logic b);
        sw_f[0] = b;
        btn_f   = 1'b1;
        repeat (2) @(posedge clk);
        #1 btn_f = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] prog(input logic [15:0] l);
        return {12'h000, l[11:8]};
    endfunction

    function automatic logic [15:0] cnt(input logic [15:0] l);
        return {8'h00, l[7:0]};
    endfunction

    logic [6:0] bits;
    int         exp_ovl[7];
    int         exp_non[7];

    initial begin
        checks = 0; errors = 0;
        run_m = 0; last_run_m = 0; run_f = 0; last_run_f = 0;
        bits    = 7'b1011011;
        exp_ovl = '{1, 2, 3, 4, 2, 3, 4};
        exp_non = '{1, 2, 3, 4, 0, 1, 1};
        sw_m = 3'b000; btn_m = 1'b0;
        sw_f = 3'b000; btn_f = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_led_m", led_m, 16'h0000);
        chk("reset_led_f", led_f, 16'h0000);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        sw_m[1] = 1'b1;
        for (int i = 0; i < 7; i++) begin
            main_step(bits[6-i]);
            chk("ovl_prog", prog(led_m), 16'(exp_ovl[i]));
        end
        chk("ovl_cnt", cnt(led_m), 16'd2);

        main_clear();
        chk("clear_led", led_m, 16'h0000);
        sw_m[1] = 1'b0;
        for (int i = 0; i < 7; i++) begin
            main_step(bits[6-i]);
            chk("non_prog", prog(led_m), 16'(exp_non[i]));
        end
        chk("non_cnt", cnt(led_m), 16'd1);

        main_clear();
        main_seq4();
        repeat (12) @(posedge clk);
        #1;
        chk("stretch_len", 16'(last_run_m), 16'd8);
        chk("stretch_cnt", cnt(led_m), 16'd1);

        // From state 4 (non-overlap): 1 -> 1, 0 -> 2; then a step with clear in its pulse cycle.
        main_step(1'b1);
        main_step(1'b0);
        chk("pre_clr_prog", prog(led_m), 16'd2);
        sw_m[0] = 1'b1;
        btn_m   = 1'b1;
        repeat (4) @(posedge clk);
        #1 sw_m[2] = 1'b1;
        @(posedge clk);
        #1 sw_m[2] = 1'b0;
        repeat (4) @(posedge clk);
        #1 btn_m = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("clr_step_led", led_m, 16'h0000);

        main_step(1'b1);
        sw_m[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            btn_m = 1'b1;
            repeat (2) @(posedge clk);
            #1 btn_m = 1'b0;
            repeat (2) @(posedge clk);
            #1;
        end
        chk("bounce_none", prog(led_m), 16'd1);
        btn_m = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("bounce_early", prog(led_m), 16'd1);
        @(posedge clk);
        #1;
        chk("bounce_step", prog(led_m), 16'd2);
        repeat (4) @(posedge clk);
        #1 btn_m = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("bounce_release", prog(led_m), 16'd2);

        main_clear();
        for (int i = 0; i < 255; i++) main_seq4();
        chk("wrap_255", cnt(led_m), 16'd255);
        main_seq4();
        chk("wrap_0", cnt(led_m), 16'd0);
        chk("wrap_prog", prog(led_m), 16'd4);

        sw_f = 3'b110;
        repeat (4) @(posedge clk);
        #1 sw_f[2] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        fast_step(1'b1);
        fast_step(1'b0);
        fast_step(1'b1);
        fast_step(1'b0);
        chk("fast_match", led_f, 16'h8401);
        fast_step(1'b1);
        chk("fast_fail3", prog(led_f), 16'd3);
        fast_step(1'b0);
        chk("fast_cnt2", cnt(led_f), 16'd2);
        repeat (40) @(posedge clk);
        #1;
        chk("retrig_len", 16'(last_run_f), 16'd26);

        main_step(1'b1);
        main_step(1'b0);
        main_step(1'b1);
        fast_step(1'b1);
        fast_step(1'b0);
        fast_step(1'b1);
        chk("pre_rst_f", led_f, 16'h8303);
        chk("pre_rst_m", prog(led_m), 16'd3);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_f", led_f, 16'h0000);
        chk("async_rst_m", led_m, 16'h0000);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        main_seq4();
        chk("recover_cnt", cnt(led_m), 16'd1);
        chk("recover_prog", prog(led_m), 16'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
